// File: rtl/spi_master_engine_pkg.sv
// Types and helpers shared by the SPI master engine and its clock generator.
`include "spi_defines.v"

package spi_master_engine_pkg;

    localparam int unsigned MAX_CHAR = `SPI_MAX_CHAR;
    localparam int unsigned LEN_W    = `SPI_CHAR_LEN_BITS;
    localparam int unsigned SS_W     = `SPI_SS_NB;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Edge/bit-order options captured at the start of a transfer
    typedef struct packed {
        logic tx_negedge;
        logic rx_negedge;
        logic lsb;
    } spi_mode_t;

    // char_len of 0 stands for the longest transfer
    function automatic logic [CNT_W-1:0] char_len_decode(input logic [LEN_W-1:0] cl);
        return (cl == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(cl);
    endfunction

    // Data bit handled in slot cnt of a len-bit transfer
    function automatic logic [IDX_W-1:0] bit_index(input logic             lsb,
                                                   input logic [CNT_W-1:0] len,
                                                   input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] msb_idx;
        msb_idx = len - cnt - CNT_W'(1);
        return lsb ? IDX_W'(cnt) : IDX_W'(msb_idx);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator.
// Ports:
//   wb_clk_i, wb_rst_i : system clock, synchronous active-high reset
//   start              : load the divider and park sclk low
//   enable             : run the divider counter
//   divider            : sclk half-period is divider+1 clock cycles
//   sclk               : serial clock
//   pos_edge, neg_edge : one-cycle strobes in the cycle after sclk rose / fell
module spi_clk_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             enable,
    input  logic [DIV_W-1:0] divider,
    output logic             sclk,
    output logic             pos_edge,
    output logic             neg_edge
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // Down-counter reloads from the captured divider and toggles sclk at zero
    always_ff @(posedge wb_clk_i) begin
        pos_edge <= 1'b0;
        neg_edge <= 1'b0;
        if (wb_rst_i) begin
            div_q <= '0;
            cnt   <= '0;
            sclk  <= 1'b0;
        end else if (start) begin
            div_q <= divider;
            cnt   <= divider;
            sclk  <= 1'b0;
        end else if (enable) begin
            if (cnt == '0) begin
                cnt      <= div_q;
                sclk     <= ~sclk;
                pos_edge <= ~sclk;
                neg_edge <= sclk;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_defines.v
// Shared SPI master definitions.
//   SPI_SS_NB          number of slave-select lines
//   SPI_MAX_CHAR       longest transfer in bits
//   SPI_CHAR_LEN_BITS  width of the char_len field (0 encodes SPI_MAX_CHAR)
`ifndef SPI_DEFINES_V
`define SPI_DEFINES_V

`define SPI_SS_NB         8
`define SPI_MAX_CHAR      128
`define SPI_CHAR_LEN_BITS 7

`endif

// File: rtl/spi_master_engine.sv
// SPI master transfer engine: shift register, bit counters and control.
// Build option: define SPI_AUTO_SS_EN to assert slave selects only while busy;
// otherwise ss_pad_o follows ~ss_sel directly.
// Ports:
//   wb_clk_i, wb_rst_i        : system clock, synchronous active-high reset
//   go                        : one-cycle start pulse (ignored while busy)
//   divider                   : sclk half-period is divider+1 cycles
//   char_len                  : bits per transfer, 0 = 128
//   tx_negedge/rx_negedge/lsb : drive edge, sample edge, bit order
//   ss_sel                    : slave-select mask, 1 = selected
//   tx_data / rx_data         : transmit word / received word
//   busy, done                : transfer active / one-cycle completion pulse
//   sclk_pad_o, mosi_pad_o, ss_pad_o (active-low), miso_pad_i : SPI pins
`include "spi_defines.v"

module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          go,
    input  logic [DIV_W-1:0]              divider,
    input  logic [`SPI_CHAR_LEN_BITS-1:0] char_len,
    input  logic                          tx_negedge,
    input  logic                          rx_negedge,
    input  logic                          lsb,
    input  logic [`SPI_SS_NB-1:0]         ss_sel,
    input  logic [`SPI_MAX_CHAR-1:0]      tx_data,
    output logic [`SPI_MAX_CHAR-1:0]      rx_data,
    output logic                          busy,
    output logic                          done,
    output logic                          sclk_pad_o,
    output logic                          mosi_pad_o,
    output logic [`SPI_SS_NB-1:0]         ss_pad_o,
    input  logic                          miso_pad_i
);

    state_t                  state;
    spi_mode_t               mode_q;
    logic [MAX_CHAR-1:0]     tx_q;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        tx_cnt;
    logic [CNT_W-1:0]        rx_cnt;
    logic [CNT_W-1:0]        per_cnt;

    logic                    pos_edge;
    logic                    neg_edge;
    logic                    start_c;
    logic                    tx_edge_c;
    logic                    rx_edge_c;
    logic                    last_period_c;
    logic                    finish_c;
    logic                    clk_en_c;
    logic [CNT_W-1:0]        len_in_c;

    assign start_c       = go && (state == ST_IDLE);
    assign len_in_c      = char_len_decode(char_len);
    assign tx_edge_c     = mode_q.tx_negedge ? neg_edge : pos_edge;
    assign rx_edge_c     = mode_q.rx_negedge ? neg_edge : pos_edge;
    assign last_period_c = (per_cnt == len_q - CNT_W'(1));
    // The final falling edge ends the transfer; freeze sclk low from then on
    assign finish_c      = (state == ST_XFER) && neg_edge && last_period_c;
    assign clk_en_c      = (state == ST_XFER) && !finish_c;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (start_c),
        .enable   (clk_en_c),
        .divider  (divider),
        .sclk     (sclk_pad_o),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge)
    );

    // Transfer control, shift data and completion
    always_ff @(posedge wb_clk_i) begin
        done <= 1'b0;
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            mosi_pad_o <= 1'b0;
            rx_data    <= '0;
            tx_q       <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            per_cnt    <= '0;
`ifdef SPI_AUTO_SS_EN
            ss_pad_o   <= '1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_XFER;
                        busy       <= 1'b1;
                        tx_q       <= tx_data;
                        len_q      <= len_in_c;
                        mode_q     <= '{tx_negedge: tx_negedge,
                                        rx_negedge: rx_negedge,
                                        lsb:        lsb};
                        rx_data    <= '0;
                        tx_cnt     <= '0;
                        rx_cnt     <= '0;
                        per_cnt    <= '0;
                        mosi_pad_o <= tx_data[bit_index(lsb, len_in_c, CNT_W'(0))];
`ifdef SPI_AUTO_SS_EN
                        ss_pad_o   <= ~ss_sel;
`endif
                    end
                end
                ST_XFER: begin
                    if (rx_edge_c && (rx_cnt < len_q)) begin
                        rx_data[bit_index(mode_q.lsb, len_q, rx_cnt)] <= miso_pad_i;
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                    // No advance once the final bit is on the line
                    if (tx_edge_c && ((tx_cnt + CNT_W'(1)) < len_q)) begin
                        tx_cnt     <= tx_cnt + CNT_W'(1);
                        mosi_pad_o <= tx_q[bit_index(mode_q.lsb, len_q, tx_cnt + CNT_W'(1))];
                    end
                    if (neg_edge) begin
                        per_cnt <= per_cnt + CNT_W'(1);
                    end
                    if (finish_c) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mosi_pad_o <= 1'b0;
`ifdef SPI_AUTO_SS_EN
                        ss_pad_o   <= '1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SPI_AUTO_SS_EN
    // Slave selects follow the mask directly, regardless of transfer state
    assign ss_pad_o = ~ss_sel;
`endif

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed self-checking bench for spi_master_engine.
module tb_spi_master_engine;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned SS_NB = 8;

    logic               clk;
    logic               rst;
    logic               go;
    logic [DIV_W-1:0]   divider;
    logic [6:0]         char_len;
    logic               tx_negedge;
    logic               rx_negedge;
    logic               lsb;
    logic [SS_NB-1:0]   ss_sel;
    logic [127:0]       tx_data;
    logic [127:0]       rx_data;
    logic               busy;
    logic               done;
    logic               sclk;
    logic               mosi;
    logic [SS_NB-1:0]   ss_pad;
    logic               miso;

    int unsigned vecs;
    int unsigned errs;

    // Observations gathered by run_xfer
    int unsigned  rises, falls, busy_cyc, dones, first_rise_cyc, last_fall_cyc, gap_bad;
    logic [127:0] mosi_log;
    logic         done_busy, done_sclk, done_mosi;
    logic         slave_mode;
    logic [7:0]   slv_sh;

`ifdef SPI_AUTO_SS_EN
    localparam logic [SS_NB-1:0] SS_IDLE = 8'hFF;
`else
    localparam logic [SS_NB-1:0] SS_IDLE = 8'hFB;
`endif
    localparam logic [SS_NB-1:0] SS_BUSY = 8'hFB;

    spi_master_engine #(.DIV_W(DIV_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .go         (go),
        .divider    (divider),
        .char_len   (char_len),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .lsb        (lsb),
        .ss_sel     (ss_sel),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .busy       (busy),
        .done       (done),
        .sclk_pad_o (sclk),
        .mosi_pad_o (mosi),
        .ss_pad_o   (ss_pad),
        .miso_pad_i (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_go();
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    // Step cycles until done (or budget), logging sclk edges, mosi at each rise,
    // and driving the shift-register slave on each fall.
    task automatic run_xfer(input int unsigned max_cyc, input int inject_at,
                            input int unsigned exp_gap, output logic finished);
        logic        prev;
        int unsigned cyc;
        int unsigned last_rise;
        rises = 0; falls = 0; busy_cyc = 0; dones = 0; gap_bad = 0;
        first_rise_cyc = 0; last_fall_cyc = 0; mosi_log = '0;
        done_busy = 1'bx; done_sclk = 1'bx; done_mosi = 1'bx;
        finished = 1'b0; prev = sclk; cyc = 0; last_rise = 0;
        while (!finished && cyc < max_cyc) begin
            if (busy) busy_cyc++;
            go = (int'(cyc) == inject_at);
            @(posedge clk); #1;
            go = 1'b0;
            cyc++;
            if (sclk && !prev) begin
                rises++;
                mosi_log = {mosi_log[126:0], mosi};
                if (rises == 1) first_rise_cyc = cyc;
                else if (cyc - last_rise != exp_gap) gap_bad++;
                last_rise = cyc;
            end
            if (!sclk && prev) begin
                falls++;
                last_fall_cyc = cyc;
                if (slave_mode) begin
                    slv_sh = {slv_sh[6:0], 1'b0};
                    miso   = slv_sh[7];
                end
            end
            prev = sclk;
            if (done) begin
                dones++;
                finished  = 1'b1;
                done_busy = busy;
                done_sclk = sclk;
                done_mosi = mosi;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
        vecs++; if (sclk !== 1'b0) begin errs++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        vecs++; if (mosi !== 1'b0) begin errs++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        vecs++; if (rx_data !== 128'h0) begin errs++; $display("FAIL reset_rx: got %h want 0", rx_data); end
        vecs++; if (ss_pad !== SS_IDLE) begin errs++; $display("FAIL reset_ss: got %h want %h", ss_pad, SS_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic fin;
        int unsigned extra;
        divider = 16'd1; char_len = 7'd8; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0;
        tx_data = 128'hA5; slave_mode = 1'b1; slv_sh = 8'h3C; miso = slv_sh[7];
        pulse_go();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        vecs++; if (mosi !== 1'b1) begin errs++; $display("FAIL basic_first_bit: got %b want 1", mosi); end
        run_xfer(200, -1, 4, fin);
        vecs++; if (fin !== 1'b1) begin errs++; $display("FAIL basic_timeout: done seen %b want 1", fin); end
        vecs++; if (rises !== 8 || falls !== 8) begin errs++; $display("FAIL basic_periods: rises %0d falls %0d want 8/8", rises, falls); end
        vecs++; if (first_rise_cyc !== 2 || gap_bad !== 0) begin errs++; $display("FAIL basic_timing: first rise %0d bad gaps %0d want 2/0", first_rise_cyc, gap_bad); end
        vecs++; if (last_fall_cyc !== 32 || busy_cyc !== 33) begin errs++; $display("FAIL basic_length: last fall %0d busy %0d want 32/33", last_fall_cyc, busy_cyc); end
        vecs++; if (mosi_log !== 128'hA5) begin errs++; $display("FAIL basic_mosi: got %h want a5", mosi_log); end
        vecs++; if (rx_data !== 128'h3C) begin errs++; $display("FAIL basic_rx: got %h want 3c", rx_data); end
        vecs++; if (done_busy !== 1'b0 || done_sclk !== 1'b0 || done_mosi !== 1'b0) begin
            errs++; $display("FAIL basic_done_state: busy %b sclk %b mosi %b want 0/0/0", done_busy, done_sclk, done_mosi); end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL basic_single_done: extra pulses %0d want 0", extra); end
        vecs++; if (rx_data !== 128'h3C) begin errs++; $display("FAIL basic_rx_hold: got %h want 3c", rx_data); end
        slave_mode = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic fin;
        divider = 16'd1; char_len = 7'd4; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b1;
        tx_data = 128'h1; miso = 1'b1;
        pulse_go();
        vecs++; if (mosi !== 1'b1) begin errs++; $display("FAIL lsb_first_bit: got %b want 1", mosi); end
        run_xfer(100, -1, 4, fin);
        vecs++; if (fin !== 1'b1 || rises !== 4) begin errs++; $display("FAIL lsb_periods: done %b rises %0d want 1/4", fin, rises); end
        vecs++; if (mosi_log !== 128'h8) begin errs++; $display("FAIL lsb_mosi: got %h want 8 (order 1,0,0,0)", mosi_log); end
        vecs++; if (rx_data !== 128'hF) begin errs++; $display("FAIL lsb_rx: got %h want f", rx_data); end
    endtask

    task automatic test_max_len();
        logic fin;
        divider = 16'd0; char_len = 7'd0; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0;
        tx_data = '1; miso = 1'b1;
        pulse_go();
        run_xfer(400, -1, 2, fin);
        vecs++; if (fin !== 1'b1) begin errs++; $display("FAIL max_timeout: done seen %b want 1", fin); end
        vecs++; if (rises !== 128 || falls !== 128) begin errs++; $display("FAIL max_periods: rises %0d falls %0d want 128/128", rises, falls); end
        vecs++; if (first_rise_cyc !== 1 || gap_bad !== 0 || last_fall_cyc !== 256) begin
            errs++; $display("FAIL max_timing: first %0d gaps %0d last fall %0d want 1/0/256", first_rise_cyc, gap_bad, last_fall_cyc); end
        vecs++; if (mosi_log !== {128{1'b1}}) begin errs++; $display("FAIL max_mosi: got %h want all ones", mosi_log); end
        vecs++; if (rx_data !== {128{1'b1}}) begin errs++; $display("FAIL max_rx: got %h want all ones", rx_data); end
    endtask

    task automatic test_reset_mid();
        logic        prev;
        int unsigned r;
        int unsigned extra;
        divider = 16'd1; char_len = 7'd8; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0;
        tx_data = 128'hFF; miso = 1'b1;
        pulse_go();
        prev = sclk; r = 0;
        for (int i = 0; i < 50 && r < 3; i++) begin
            @(posedge clk); #1;
            if (sclk && !prev) r++;
            prev = sclk;
        end
        vecs++; if (r !== 3) begin errs++; $display("FAIL rstmid_reach: rises %0d want 3", r); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vecs++; if (busy !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL rstmid_idle: busy %b sclk %b mosi %b done %b want 0", busy, sclk, mosi, done); end
        vecs++; if (ss_pad !== SS_IDLE) begin errs++; $display("FAIL rstmid_ss: got %h want %h", ss_pad, SS_IDLE); end
        vecs++; if (rx_data !== 128'h0) begin errs++; $display("FAIL rstmid_rx: got %h want 0", rx_data); end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy || sclk) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL rstmid_quiet: active cycles %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic fin;
        divider = 16'd1; char_len = 7'd4; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0;
        tx_data = 128'hC; miso = 1'b0;
        pulse_go();
        // Different configuration presented with a go that must be ignored
        divider = 16'd0; char_len = 7'd2; tx_data = '0; lsb = 1'b1;
        run_xfer(100, 5, 4, fin);
        vecs++; if (fin !== 1'b1 || rises !== 4 || first_rise_cyc !== 2) begin
            errs++; $display("FAIL b2b_first: done %b rises %0d first %0d want 1/4/2", fin, rises, first_rise_cyc); end
        vecs++; if (mosi_log !== 128'hC || rx_data !== 128'h0) begin
            errs++; $display("FAIL b2b_first_data: mosi %h rx %h want c/0", mosi_log, rx_data); end
        // go lands in the done cycle
        divider = 16'd1; char_len = 7'd3; tx_data = 128'h5; lsb = 1'b0; miso = 1'b1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        vecs++; if (busy !== 1'b1 || mosi !== 1'b1) begin errs++; $display("FAIL b2b_restart: busy %b mosi %b want 1/1", busy, mosi); end
        run_xfer(100, -1, 4, fin);
        vecs++; if (fin !== 1'b1 || rises !== 3 || mosi_log !== 128'h5) begin
            errs++; $display("FAIL b2b_second: done %b rises %0d mosi %h want 1/3/5", fin, rises, mosi_log); end
        vecs++; if (rx_data !== 128'h7) begin errs++; $display("FAIL b2b_second_rx: got %h want 7", rx_data); end
    endtask

    task automatic test_ss();
        logic fin;
        ss_sel = 8'h04;
        divider = 16'd1; char_len = 7'd2; tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0;
        tx_data = 128'h2; miso = 1'b0;
        @(posedge clk); #1;
        vecs++; if (ss_pad !== SS_IDLE) begin errs++; $display("FAIL ss_idle: got %h want %h", ss_pad, SS_IDLE); end
        pulse_go();
        vecs++; if (ss_pad !== SS_BUSY) begin errs++; $display("FAIL ss_busy: got %h want %h", ss_pad, SS_BUSY); end
        run_xfer(100, -1, 4, fin);
        vecs++; if (fin !== 1'b1 || ss_pad !== SS_IDLE) begin errs++; $display("FAIL ss_after: done %b ss %h want 1/%h", fin, ss_pad, SS_IDLE); end
    endtask

    initial begin
        vecs = 0; errs = 0;
        rst = 1'b1; go = 1'b0; divider = '0; char_len = '0;
        tx_negedge = 1'b0; rx_negedge = 1'b0; lsb = 1'b0;
        ss_sel = 8'h04; tx_data = '0; miso = 1'b0;
        slave_mode = 1'b0; slv_sh = '0;
        test_reset();
        test_basic();
        test_lsb_first();
        test_max_len();
        test_reset_mid();
        test_back_to_back();
        test_ss();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
